// File: rtl/pipe_mux_stage.sv
// rtl/pipe_mux_stage.sv - N-way word selector fused with a 2-entry skid-buffered pipeline stage
//
// Purpose: picks one of N packed WIDTH-bit inputs by sel and registers it into a
//          valid/ready pipeline stage. A skid entry absorbs the one word that can
//          arrive while downstream stalls, so in_ready is a registered output and
//          backpressure never forms a combinational path. flush squashes held words.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   d          in   N*WIDTH packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        in   SELW input index, sampled on input handshake
//   in_valid   in   upstream presents d/sel
//   in_ready   out  stage can accept a word (register output)
//   flush      in   synchronous squash of all held entries
//   y          out  WIDTH registered selected word
//   out_valid  out  y holds a valid word
//   out_ready  in   downstream accepts y
module pipe_mux_stage #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   d,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;

    logic             w_main_valid_n;
    logic [WIDTH-1:0] w_main_data_n;
    logic             w_skid_valid_n;
    logic [WIDTH-1:0] w_skid_data_n;

    logic [WIDTH-1:0] w_sel_word;
    logic             w_acc;
    logic             w_take;

    // Out-of-range selects (only possible for non-power-of-two N) match no
    // index and therefore yield zero.
    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                w_sel_word = d[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_acc  = in_valid & r_in_ready & ~flush;
    assign w_take = r_main_valid & out_ready;

    always_comb begin
        w_main_valid_n = r_main_valid;
        w_main_data_n  = r_main_data;
        w_skid_valid_n = r_skid_valid;
        w_skid_data_n  = r_skid_data;

        if (flush) begin
            // Data registers keep their contents; only the valid bits drop.
            w_main_valid_n = 1'b0;
            w_skid_valid_n = 1'b0;
        end else if (!r_main_valid || w_take) begin
            if (r_skid_valid) begin
                // Older skid word advances first to keep FIFO order.
                w_main_data_n  = r_skid_data;
                w_main_valid_n = 1'b1;
                w_skid_valid_n = 1'b0;
                if (w_acc) begin
                    w_skid_data_n  = w_sel_word;
                    w_skid_valid_n = 1'b1;
                end
            end else if (w_acc) begin
                w_main_data_n  = w_sel_word;
                w_main_valid_n = 1'b1;
            end else begin
                w_main_valid_n = 1'b0;
            end
        end else if (w_acc) begin
            w_skid_data_n  = w_sel_word;
            w_skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_n;
            r_main_data  <= w_main_data_n;
            r_skid_valid <= w_skid_valid_n;
            r_skid_data  <= w_skid_data_n;
            // Registered copy of !skid_valid so in_ready comes straight off a flop.
            r_in_ready   <= ~w_skid_valid_n;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign y         = r_main_data;

endmodule

// File: tb/tb_pipe_mux_stage.sv
// tb/tb_pipe_mux_stage.sv - self-checking bench for pipe_mux_stage
module tb_pipe_mux_stage;

    logic         clk;
    logic         reset;
    logic [127:0] d;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [31:0]  y;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  d3;
    logic [1:0]   sel3;
    logic         in_valid3;
    logic         in_ready3;
    logic         flush3;
    logic [31:0]  y3;
    logic         out_valid3;
    logic         out_ready3;

    int checks;
    int errors;

    pipe_mux_stage #(.WIDTH(32), .N(4)) u_dut (
        .clk(clk), .reset(reset), .d(d), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .y(y), .out_valid(out_valid), .out_ready(out_ready)
    );

    pipe_mux_stage #(.WIDTH(32), .N(3)) u_dut3 (
        .clk(clk), .reset(reset), .d(d3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .y(y3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; d = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        d3 = '0; sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y actual=%h required=00000000", y); end
        step();
        step();
        #2 reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle actual=%b%b required=01", out_valid, in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        d = {32'h0, 32'h0, 32'h6b58400b, 32'h419c03fc};
        sel = 2'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 32'h419c03fc) begin errors++; $display("FAIL single_sel0 actual=%b/%h required=1/419c03fc", out_valid, y); end
        sel = 2'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 32'h6b58400b) begin errors++; $display("FAIL single_sel1 actual=%b/%h required=1/6b58400b", out_valid, y); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain actual=%b required=0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] w [4];
        for (int k = 0; k < 4; k++) w[k] = $urandom() ^ (32'h1111_0000 * k);
        d = {w[3], w[2], w[1], w[0]};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k); in_valid = 1'b1;
            step();
            checks++; if (out_valid !== 1'b1 || y !== w[k]) begin errors++; $display("FAIL stream_word%0d actual=%b/%h required=1/%h", k, out_valid, y, w[k]); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d actual=%b required=1", k, in_ready); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain actual=%b required=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; sel = 2'd0;
        d = {96'h0, 32'h74d7edc6}; in_valid = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_first actual=%b required=1", in_ready); end
        d = {96'h0, 32'hb6f0d434};
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_second actual=%b required=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || y !== 32'h74d7edc6) begin errors++; $display("FAIL bp_head actual=%b/%h required=1/74d7edc6", out_valid, y); end
        d = {96'h0, 32'h11112222};
        step();
        checks++; if (in_ready !== 1'b0 || y !== 32'h74d7edc6) begin errors++; $display("FAIL bp_hold actual=%b/%h required=0/74d7edc6", in_ready, y); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || y !== 32'hb6f0d434) begin errors++; $display("FAIL bp_second_out actual=%b/%h required=1/b6f0d434", out_valid, y); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_restored actual=%b required=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_third actual=%b/%h required=0", out_valid, y); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; sel = 2'd0; in_valid = 1'b1;
        d = {96'h0, 32'h0badf00d};
        step();
        d = {96'h0, 32'h5eed1234};
        step();
        flush = 1'b1; d = {96'h0, 32'hdc2242bd};
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state actual=%b%b required=01", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b0 || y === 32'hdc2242bd) begin errors++; $display("FAIL flush_squash%0d actual=%b/%h required=0/not dc2242bd", k, out_valid, y); end
        end
    endtask

    task automatic test_n3();
        d3 = {32'hba5fb2db, 32'h12345678, 32'h9abcdef0};
        sel3 = 2'd3; in_valid3 = 1'b1;
        step();
        checks++; if (out_valid3 !== 1'b1 || y3 !== 32'h0) begin errors++; $display("FAIL n3_out_of_range actual=%b/%h required=1/00000000", out_valid3, y3); end
        sel3 = 2'd2;
        step();
        in_valid3 = 1'b0;
        checks++; if (out_valid3 !== 1'b1 || y3 !== 32'hba5fb2db) begin errors++; $display("FAIL n3_sel2 actual=%b/%h required=1/ba5fb2db", out_valid3, y3); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; sel = 2'd1; in_valid = 1'b1;
        d = {64'h0, 32'hcafef00d, 32'h0};
        step();
        d = {64'h0, 32'hfeedbeef, 32'h0};
        step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 32'h0) begin errors++; $display("FAIL async_reset actual=%b%b/%h required=01/00000000", out_valid, in_ready, y); end
        step();
        #2 reset = 1'b0;
        step();
        out_ready = 1'b1; sel = 2'd3; d = {32'h87654321, 96'h0}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 32'h87654321) begin errors++; $display("FAIL after_reset_accept actual=%b/%h required=1/87654321", out_valid, y); end
        step();
        step();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic        acc;
        logic        take;
        logic [31:0] word;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            d         = {$urandom(), $urandom(), $urandom(), $urandom()};
            sel       = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) < 3);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_in_ready cyc=%0d actual=%b required=%b", c, in_ready, q.size() < 2); end
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_out_valid cyc=%0d actual=%b required=%b", c, out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (y !== q[0]) begin errors++; $display("FAIL rand_y cyc=%0d actual=%h required=%h", c, y, q[0]); end
            end
            word = d[32*sel +: 32];
            acc  = in_valid && (q.size() < 2) && !flush;
            take = (q.size() > 0) && out_ready;
            step();
            if (flush) begin
                q.delete();
            end else begin
                if (take) void'(q.pop_front());
                if (acc) q.push_back(word);
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain actual=%b required=0", out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_flush();
        test_n3();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
